rxuart: RTL and testbench

RXUART -- requirements
Module: rxuart

---
 rtl/rxuart.sv | 246 ++++++++++++++++++++++++
 tb/tb_rxuart.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rxuart.sv
// ---------------------------------------------------------------------------
// rxuart - 8-bit asynchronous serial receiver (start, 8 data LSB first,
//          optional even parity, 1 stop).
//
// Optional feature: define RXUART_PARITY_EN to compile in an even-parity
// bit between the data bits and the stop bit (11-bit frame). Without it the
// frame is 10 bits and o_parity_err is tied low.
//
// Ports
//   i_clk         system clock, rising edge
//   i_reset       synchronous active-high reset
//   i_setup       clocks per baud period, latched at each start edge
//   i_uart        asynchronous serial line, idle high
//   o_wr          one-cycle strobe, o_data/o_frame_err/o_parity_err valid
//   o_data        received byte (held until next o_wr)
//   o_frame_err   stop bit sampled low (held until next o_wr)
//   o_parity_err  parity mismatch (held until next o_wr)
//   o_busy        high whenever the receiver is not idle
//
// State | meaning
//   IDLE   | waiting for a falling edge on the synchronized line
//   START  | counting half a bit to re-check the start bit mid-bit
//   DATA   | sampling the 8 data bits mid-bit
//   PARITY | sampling the parity bit (RXUART_PARITY_EN only)
//   STOP   | sampling the stop bit, publishes the byte
//   BREAK  | stop bit was low; wait for one full baud period of idle line
// ---------------------------------------------------------------------------
module rxuart (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [23:0] i_setup,
    input  logic        i_uart,
    output logic        o_wr,
    output logic [7:0]  o_data,
    output logic        o_frame_err,
    output logic        o_parity_err,
    output logic        o_busy
);

    localparam logic [23:0] MIN_BAUD = 24'd16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef RXUART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    // Line synchronizer and edge detect
    logic        r_sync1;
    logic        r_sync2;
    logic        r_line_prev;
    logic        w_line;
    logic        w_fall;

    // FSM / datapath registers
    state_t      r_state;
    state_t      w_state_next;
    logic [23:0] r_baud;
    logic [23:0] w_baud_next;
    logic [23:0] r_cnt;
    logic [23:0] w_cnt_next;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;

    // Output registers
    logic        r_wr;
    logic        w_wr_next;
    logic [7:0]  r_data;
    logic [7:0]  w_data_next;
    logic        r_frame_err;
    logic        w_frame_err_next;

`ifdef RXUART_PARITY_EN
    logic        r_par_bit;
    logic        w_par_bit_next;
    logic        r_parity_err;
    logic        w_parity_err_next;
`endif

    logic [23:0] w_setup_eff;
    logic [23:0] w_reload;
    logic        w_cnt_zero;

    assign w_line      = r_sync2;
    assign w_fall      = r_line_prev & ~r_sync2;
    assign w_setup_eff = (i_setup < MIN_BAUD) ? MIN_BAUD : i_setup;
    assign w_reload    = r_baud - 24'd1;
    assign w_cnt_zero  = (r_cnt == 24'd0);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_line_prev <= 1'b1;
            r_state     <= ST_IDLE;
            r_baud      <= 24'd0;
            r_cnt       <= 24'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_wr        <= 1'b0;
            r_data      <= 8'h00;
            r_frame_err <= 1'b0;
`ifdef RXUART_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sync1     <= i_uart;
            r_sync2     <= r_sync1;
            r_line_prev <= r_sync2;
            r_state     <= w_state_next;
            r_baud      <= w_baud_next;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_wr        <= w_wr_next;
            r_data      <= w_data_next;
            r_frame_err <= w_frame_err_next;
`ifdef RXUART_PARITY_EN
            r_par_bit    <= w_par_bit_next;
            r_parity_err <= w_parity_err_next;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_baud_next      = r_baud;
        w_cnt_next       = w_cnt_zero ? r_cnt : (r_cnt - 24'd1);
        w_bit_idx_next   = r_bit_idx;
        w_shift_next     = r_shift;
        w_wr_next        = 1'b0;
        w_data_next      = r_data;
        w_frame_err_next = r_frame_err;
`ifdef RXUART_PARITY_EN
        w_par_bit_next    = r_par_bit;
        w_parity_err_next = r_parity_err;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    // Baud is frozen for the whole frame; first sample lands
                    // mid start bit.
                    w_state_next = ST_START;
                    w_baud_next  = w_setup_eff;
                    w_cnt_next   = (w_setup_eff >> 1) - 24'd1;
                end
            end

            ST_START: begin
                if (w_cnt_zero) begin
                    if (!w_line) begin
                        w_state_next   = ST_DATA;
                        w_cnt_next     = w_reload;
                        w_bit_idx_next = 3'd0;
                    end else begin
                        // Glitch: line back high mid start bit
                        w_state_next = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (w_cnt_zero) begin
                    w_shift_next = {w_line, r_shift[7:1]};
                    w_cnt_next   = w_reload;
                    if (r_bit_idx == 3'd7) begin
`ifdef RXUART_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end

`ifdef RXUART_PARITY_EN
            ST_PARITY: begin
                if (w_cnt_zero) begin
                    w_par_bit_next = w_line;
                    w_cnt_next     = w_reload;
                    w_state_next   = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                if (w_cnt_zero) begin
                    w_wr_next        = 1'b1;
                    w_data_next      = r_shift;
                    w_frame_err_next = ~w_line;
`ifdef RXUART_PARITY_EN
                    // Even parity: data bits plus parity bit XOR to zero
                    w_parity_err_next = (^r_shift) ^ r_par_bit;
`endif
                    if (w_line) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_BREAK;
                        w_cnt_next   = w_reload;
                    end
                end
            end

            ST_BREAK: begin
                // Any low cycle restarts the one-baud idle qualification
                if (!w_line) begin
                    w_cnt_next = w_reload;
                end else if (w_cnt_zero) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_wr        = r_wr;
    assign o_data      = r_data;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != ST_IDLE);
`ifdef RXUART_PARITY_EN
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rxuart.sv
// ---------------------------------------------------------------------------
// tb_rxuart - directed self-checking bench for rxuart.
// Builds with or without RXUART_PARITY_EN; frame length follows the macro.
// ---------------------------------------------------------------------------
module tb_rxuart;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [23:0] i_setup;
    logic        i_uart;
    logic        o_wr;
    logic [7:0]  o_data;
    logic        o_frame_err;
    logic        o_parity_err;
    logic        o_busy;

`ifdef RXUART_PARITY_EN
    localparam int NBITS = 10;   // start + 8 data + parity before stop
`else
    localparam int NBITS = 9;    // start + 8 data before stop
`endif
    localparam int BAUD = 40;

    rxuart dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_setup      (i_setup),
        .i_uart       (i_uart),
        .o_wr         (o_wr),
        .o_data       (o_data),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // o_wr monitor, sampled on the falling edge
    int         wr_count = 0;
    int         wr_cyc   = 0;
    logic [7:0] wr_data  = 8'h00;
    logic       wr_ferr  = 1'b0;
    logic       wr_perr  = 1'b0;
    always @(negedge i_clk) begin
        if (o_wr) begin
            wr_count = wr_count + 1;
            wr_cyc   = cyc;
            wr_data  = o_data;
            wr_ferr  = o_frame_err;
            wr_perr  = o_parity_err;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int b);
        i_uart = v;
        tick(b);
    endtask

    int fall_cyc = 0;

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int b);
        fall_cyc = cyc;
        drive_bit(1'b0, b);
        for (int i = 0; i < 8; i++) drive_bit(d[i], b);
`ifdef RXUART_PARITY_EN
        drive_bit(par, b);
`else
        if (par === 1'bx) $display("parity argument unused");
`endif
        drive_bit(stp, b);
    endtask

    // Falling edge is synchronized two clocks after it is driven; o_wr must
    // follow the synchronized edge by 2 + b/2 + NBITS*b cycles, +/-1.
    task automatic check_latency(input string tag, input int b);
        int nominal;
        int lat;
        nominal = 2 + 2 + (b / 2) + NBITS * b;
        lat     = wr_cyc - fall_cyc;
        check_eq(tag, ((lat >= nominal - 1) && (lat <= nominal + 1)) ? 32'd1 : 32'd0, 32'd1);
        if ((lat < nominal - 1) || (lat > nominal + 1))
            $display("  latency %0d, window %0d..%0d", lat, nominal - 1, nominal + 1);
    endtask

    int n0;

    initial begin
        i_reset = 1'b1;
        i_uart  = 1'b1;
        i_setup = 24'd40;
        tick(5);
        check_eq("rst_wr",   {31'd0, o_wr},         32'd0);
        check_eq("rst_data", {24'd0, o_data},       32'h00);
        check_eq("rst_ferr", {31'd0, o_frame_err},  32'd0);
        check_eq("rst_perr", {31'd0, o_parity_err}, 32'd0);
        check_eq("rst_busy", {31'd0, o_busy},       32'd0);
        i_reset = 1'b0;
        tick(5);

        // Single frame A0; i_setup changed mid-frame must be ignored
        n0 = wr_count;
        fork
            send_frame(8'hA0, 1'b0, 1'b1, BAUD);
            begin
                tick(10);
                check_eq("a0_busy_mid", {31'd0, o_busy}, 32'd1);
                i_setup = 24'd100;
            end
        join
        tick(5);
        check_eq("a0_count", wr_count, n0 + 1);
        check_eq("a0_data",  {24'd0, wr_data}, 32'hA0);
        check_eq("a0_ferr",  {31'd0, wr_ferr}, 32'd0);
        check_eq("a0_perr",  {31'd0, wr_perr}, 32'd0);
        check_latency("a0_latency", BAUD);
        check_eq("a0_busy_end", {31'd0, o_busy}, 32'd0);
        check_eq("a0_hold", {24'd0, o_data}, 32'hA0);
        i_setup = 24'd40;

        // Back-to-back A0 then 30, no idle gap
        n0 = wr_count;
        send_frame(8'hA0, 1'b0, 1'b1, BAUD);
        check_eq("b2b_first_count", wr_count, n0 + 1);
        check_eq("b2b_first_data", {24'd0, wr_data}, 32'hA0);
        send_frame(8'h30, 1'b0, 1'b1, BAUD);
        tick(5);
        check_eq("b2b_second_count", wr_count, n0 + 2);
        check_eq("b2b_second_data", {24'd0, wr_data}, 32'h30);

        // Baud below 16 is clamped to 16
        i_setup = 24'd5;
        n0 = wr_count;
        send_frame(8'hC3, 1'b0, 1'b1, 16);
        tick(5);
        check_eq("clamp_count", wr_count, n0 + 1);
        check_eq("clamp_data", {24'd0, wr_data}, 32'hC3);
        check_latency("clamp_latency", 16);

        // False start at the 9600-baud setting
        i_setup = 24'd10416;
        n0 = wr_count;
        i_uart = 1'b0;
        tick(1000);
        check_eq("fs_busy_low", {31'd0, o_busy}, 32'd1);
        i_uart = 1'b1;
        tick(5300);
        check_eq("fs_busy_end", {31'd0, o_busy}, 32'd0);
        check_eq("fs_no_wr", wr_count, n0);
        i_setup = 24'd40;

        // Framing error then break
        n0 = wr_count;
        send_frame(8'h55, 1'b0, 1'b0, BAUD);
        drive_bit(1'b0, 3 * BAUD);
        check_eq("brk_count", wr_count, n0 + 1);
        check_eq("brk_data", {24'd0, wr_data}, 32'h55);
        check_eq("brk_ferr", {31'd0, wr_ferr}, 32'd1);
        check_eq("brk_busy_low", {31'd0, o_busy}, 32'd1);
        i_uart = 1'b1;
        tick(20);
        check_eq("brk_busy_half", {31'd0, o_busy}, 32'd1);
        tick(30);
        check_eq("brk_busy_end", {31'd0, o_busy}, 32'd0);
        check_eq("brk_no_extra_wr", wr_count, n0 + 1);

        // Reset during bit 4 of 30, then a full 30 frame
        n0 = wr_count;
        drive_bit(1'b0, BAUD);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, BAUD);   // 30: bits 0..3 = 0
        i_uart = 1'b1;                                        // bit 4 = 1
        tick(BAUD / 2);
        i_reset = 1'b1;
        tick(1);
        check_eq("mrst_wr",   {31'd0, o_wr},         32'd0);
        check_eq("mrst_data", {24'd0, o_data},       32'h00);
        check_eq("mrst_ferr", {31'd0, o_frame_err},  32'd0);
        check_eq("mrst_busy", {31'd0, o_busy},       32'd0);
        i_reset = 1'b0;
        tick(3 * BAUD);
        check_eq("mrst_no_wr", wr_count, n0);
        send_frame(8'h30, 1'b0, 1'b1, BAUD);
        tick(5);
        check_eq("mrst_next_count", wr_count, n0 + 1);
        check_eq("mrst_next_data", {24'd0, wr_data}, 32'h30);
        check_eq("mrst_next_ferr", {31'd0, wr_ferr}, 32'd0);

`ifdef RXUART_PARITY_EN
        // 07 has three ones: even parity bit must be 1
        send_frame(8'h07, 1'b0, 1'b1, BAUD);
        tick(5);
        check_eq("par0_data", {24'd0, wr_data}, 32'h07);
        check_eq("par0_perr", {31'd0, wr_perr}, 32'd1);
        send_frame(8'h07, 1'b1, 1'b1, BAUD);
        tick(5);
        check_eq("par1_data", {24'd0, wr_data}, 32'h07);
        check_eq("par1_perr", {31'd0, wr_perr}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
